// File: rtl/uart_tx_fifo_if.sv
// Host write port and transmitter handshake for the UART transmit FIFO.
// The master side is the host plus the transmitter; the FIFO is the slave.
interface uart_tx_fifo_if #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int DEPTH            = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                        wr_en;
    logic [INPUT_DATA_WIDTH-1:0] wr_data;
    logic                        full;
    logic                        empty;
    logic [CNT_W-1:0]            count;
    logic                        overflow;
    logic                        tx_enable;
    logic [INPUT_DATA_WIDTH-1:0] tx_data;
    logic                        tx_busy;
    logic                        tx_error;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, overflow, tx_enable, tx_data, tx_error
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, overflow, tx_enable, tx_data, tx_error
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter: buffers host bytes and
// issues them one per frame as a single-cycle enable with data held stable.
// A transmitter that never acknowledges a start sets a sticky error.
module uart_tx_fifo #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int DEPTH            = 16,
    parameter int START_TIMEOUT    = 4
) (
    input logic          clk,
    input logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_SENDING
    } state_t;

    state_t                      state_q, state_d;
    logic [INPUT_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [TMO_W-1:0]            tmo_q, tmo_d;
    logic                        overflow_q, overflow_d;
    logic                        tx_enable_q, tx_enable_d;
    logic [INPUT_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                        tx_error_q, tx_error_d;
    logic                        full_w;
    logic                        wr_accept;
    logic                        pop;

    // Flags decode from the registered count, so a same-cycle pop never
    // rescues a write that arrives while full.
    assign full_w    = (count_q == CNT_FULL);
    assign wr_accept = bus.wr_en && !full_w;

    // Next-state: transmit handshake FSM, occupancy and pointer bookkeeping.
    always_comb begin
        state_d     = state_q;
        tx_enable_d = 1'b0;
        tx_data_d   = tx_data_q;
        tx_error_d  = tx_error_q;
        tmo_d       = tmo_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && !bus.tx_busy) begin
                    pop         = 1'b1;
                    tx_data_d   = mem_q[rd_ptr_q];
                    tx_enable_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    tmo_d   = '0;
                    state_d = S_SENDING;
                end else if (tmo_q == TMO_LAST) begin
                    // Transmitter never started: the byte is dropped.
                    tmo_d      = '0;
                    tx_error_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_SENDING: begin
                if (!bus.tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        overflow_d = bus.wr_en && full_w;
        wr_ptr_d   = wr_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers with synchronous flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            overflow_q  <= 1'b0;
            tx_enable_q <= 1'b0;
            tx_data_q   <= '0;
            tx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            overflow_q  <= overflow_d;
            tx_enable_q <= tx_enable_d;
            tx_data_q   <= tx_data_d;
            tx_error_q  <= tx_error_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.full      = full_w;
    assign bus.empty     = (count_q == '0);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.tx_enable = tx_enable_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_error  = tx_error_q;
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer placed directly upstream of the UART transmitter. It accepts bytes from a host write port into a circular FIFO and issues them one at a time to the transmitter's `enable` / `i_data` inputs. It obeys the transmitter's contract: `enable` is never asserted while the transmitter is busy or in reset, and `i_data` is held stable for the whole frame. A stuck transmitter is reported through a sticky start-timeout error.

## Interface

Parameters:
- INPUT_DATA_WIDTH, 8: byte width; matches the transmitter data width.
- DEPTH, 16: FIFO entries; must be a power of two and at least 2.
- START_TIMEOUT, 4: cycles allowed after `tx_enable` for `tx_busy` to rise.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- wr_en, input, 1: host write strobe.
- wr_data, input, INPUT_DATA_WIDTH: host byte.
- full, output, 1: FIFO holds DEPTH entries.
- empty, output, 1: FIFO holds 0 entries.
- count, output, $clog2(DEPTH+1): current occupancy.
- overflow, output, 1: one-cycle pulse when a write is dropped.
- tx_enable, output, 1: connects to transmitter `enable`.
- tx_data, output, INPUT_DATA_WIDTH: connects to transmitter `i_data`.
- tx_busy, input, 1: from transmitter `o_busy`.
- tx_error, output, 1: sticky start-timeout flag.

## Operation

- Storage: DEPTH x INPUT_DATA_WIDTH array, with rd_ptr and wr_ptr of width $clog2(DEPTH). Both pointers wrap modulo DEPTH. `count` is a separate register, and `full` and `empty` are decoded from it.
- Write: `wr_en && !full` writes `wr_data` at wr_ptr, then wr_ptr advances.
  - `wr_en && full` drops the byte and pulses `overflow` for one cycle. This applies even if a pop happens in the same cycle, because `full` is evaluated on the registered count.
- Pop and write in the same cycle: `count` is unchanged and both pointers advance.
- FSM states:
  - IDLE: if `!empty && !tx_busy`, pop the head. On that edge, `tx_data <= mem[rd_ptr]`, rd_ptr advances, count decrements, `tx_enable <= 1`, and the FSM goes to WAIT_BUSY. Otherwise the FSM stays in IDLE. A `tx_busy` that is high while in IDLE blocks the pop.
  - WAIT_BUSY: `tx_enable <= 0` and the timeout counter increments each cycle.
    - If `tx_busy` = 1, go to SENDING.
    - If the counter reaches START_TIMEOUT, set `tx_error`, go to IDLE, and treat the byte as lost.
  - SENDING: wait for `tx_busy` = 0, then go to IDLE.
- `tx_data` changes only on a pop edge. It holds its value through WAIT_BUSY, SENDING and IDLE until the next pop.
- `tx_error` stays set until reset. Operation continues normally after it is set.
- Reset during any state: the FIFO is flushed and all outputs return to their reset values on the next edge. Any frame already started in the transmitter is not tracked.

## Timing

- Reset values: tx_enable=0, tx_data=0, full=0, empty=1, count=0, overflow=0, tx_error=0, state=IDLE, pointers=0, timeout counter=0.
- `count`, `full` and `empty` reflect a write or pop one cycle after the accepting edge.
- Latency into an idle, empty FIFO with `tx_busy`=0:
  - write accepted at edge E0;
  - pop at edge E1, so `tx_enable` is high for exactly one cycle, between E1 and E2.
- `tx_enable` is always a single-cycle pulse. It is never high while `tx_busy`=1 is sampled in IDLE, and never high during reset.
- Back-to-back bytes: `tx_busy` falls and is sampled in SENDING at edge En. The FSM is in IDLE after En, and the next pop occurs at En+1. The minimum gap is one cycle of `tx_busy`=0 between frames.
- Timeout: `tx_error` rises START_TIMEOUT cycles after the `tx_enable` pulse if `tx_busy` never rose.
- `overflow` is high in the cycle after the dropped write.

## Test plan

- Single byte: reset, then write 0xA5 with a transmitter model that raises busy 1 cycle after enable for 88 cycles. Required: `tx_enable` pulses once one cycle after the write, `tx_data`=0xA5 is stable throughout busy, and count returns to 0.
- Burst ordering: write 0x01..0x05 on consecutive cycles. Required: bytes are issued in order 0x01..0x05, one `tx_enable` per frame, each at least one cycle after busy falls, and enable is never asserted while busy=1.
- Full and overflow: hold the transmitter busy and write DEPTH+1 bytes. Required: full=1 and count=16 after the 16th write, the 17th write raises `overflow` for one cycle, and the FIFO contents are unchanged.
- Wrap-around: issue 40 writes interleaved with drains. Required: all 40 bytes are received in order and the pointers wrap cleanly.
- Timeout: the transmitter never raises busy. Required: `tx_error`=1 exactly 4 cycles after `tx_enable`, the FSM returns to IDLE, and the next byte is still issued.
- Mid-frame reset: assert reset during SENDING with 3 bytes queued. Required: on the next cycle count=0, empty=1, tx_enable=0, tx_data=0 and tx_error=0.
